// File: rtl/exp_preprocess_pipe_pkg.sv
// Shared softmax exp-preprocess configuration: default widths and the shift terms
// of the log2(e) approximation 1 + 1/2 - 1/16 (+ 1/256 with EXP_PRE_PRECISE_EN).
package exp_preprocess_pipe_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_FRAC_W   = 10;

  localparam int SH_HALF      = 1;
  localparam int SH_SIXTEENTH = 4;
  localparam int SH_PRECISE   = 8;

  typedef enum logic {
    MODE_PLAIN  = 1'b0,
    MODE_STAGE4 = 1'b1
  } lnf_mode_e;

endpackage

// File: rtl/exp_preprocess_pipe_lane.sv
// One lane of the log2(e) scaling: R = A*~1.4375 (or ~1.4414 with EXP_PRE_PRECISE_EN),
// split into a signed integer floor and an unsigned fraction.
module exp_pre_lane
  import exp_preprocess_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic signed [DATA_W+FRAC_W-1:0] a,
  output logic        [DATA_W-1:0]        u,
  output logic        [FRAC_W-1:0]        v
);

  localparam int W = DATA_W + FRAC_W;

  logic signed [W-1:0] r;

  always_comb begin
    r = a + (a >>> SH_HALF) - (a >>> SH_SIXTEENTH);
`ifdef EXP_PRE_PRECISE_EN
    r = r + (a >>> SH_PRECISE);
`endif
  end

  // Arithmetic shifts keep R two's complement, so the top bits are already the floor.
  assign u = r[W-1:FRAC_W];
  assign v = r[FRAC_W-1:0];

endmodule

// File: rtl/exp_preprocess_pipe.sv
// Two-stage exp preprocessing pipe: stage 1 forms A = (xi<<FRAC_W) + lnf, stage 2 registers
// the log2(e)-scaled integer/fraction split. EXP_PRE_PRECISE_EN selects the finer constant.
module exp_preprocess_pipe
  import exp_preprocess_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   xi,
  input  logic [DATA_W-1:0]         lnf,
  input  logic                      is_stage4,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   u,
  output logic [LANES*FRAC_W-1:0]   v,
  output logic                      out_last
);

  localparam int W = DATA_W + FRAC_W;

  logic      s1_valid, s1_last;
  logic      s2_valid, s2_last;
  logic      s1_advance, s2_load, in_fire;
  lnf_mode_e mode;
  logic [W-1:0] lnf_ext;

  assign s2_load    = !s2_valid || out_ready;
  assign s1_advance = s1_valid && s2_load;
  assign in_ready   = !s1_valid || s1_advance;
  assign in_fire    = in_valid && in_ready;

  assign mode    = lnf_mode_e'(is_stage4);
  assign lnf_ext = (mode == MODE_STAGE4) ? {{FRAC_W{lnf[DATA_W-1]}}, lnf} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        s1_last  <= in_last;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
      end
      if (s1_advance) begin
        s2_last <= s1_last;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_last  = s2_last;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [W-1:0]      a_next, a_q;
      logic [DATA_W-1:0] lane_u, u_q;
      logic [FRAC_W-1:0] lane_v, v_q;

      // Concatenation is the W-bit wrap of xi<<FRAC_W.
      assign a_next = {xi[gi*DATA_W +: DATA_W], {FRAC_W{1'b0}}} + lnf_ext;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
        end else if (in_fire) begin
          a_q <= a_next;
        end
      end

      exp_pre_lane #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
      ) u_lane (
        .a (a_q),
        .u (lane_u),
        .v (lane_v)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          u_q <= '0;
          v_q <= '0;
        end else if (s1_advance) begin
          u_q <= lane_u;
          v_q <= lane_v;
        end
      end

      assign u[gi*DATA_W +: DATA_W] = u_q;
      assign v[gi*FRAC_W +: FRAC_W] = v_q;
    end
  endgenerate

endmodule

// File: tb/tb_exp_preprocess_pipe.sv
// Scoreboard bench for exp_preprocess_pipe (DATA_W=32, FRAC_W=10, LANES=4).
module tb_exp_preprocess_pipe;

  localparam int DW = 32;
  localparam int FW = 10;
  localparam int L  = 4;
  localparam int NRAND = 10000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [L*DW-1:0]   xi = '0;
  logic [DW-1:0]     lnf = '0;
  logic              is_stage4 = 1'b0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [L*DW-1:0]   u;
  logic [L*FW-1:0]   v;
  logic              out_last;

  always #5 clk = ~clk;

  exp_preprocess_pipe #(.DATA_W(DW), .FRAC_W(FW), .LANES(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xi        (xi),
    .lnf       (lnf),
    .is_stage4 (is_stage4),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .u         (u),
    .v         (v),
    .out_last  (out_last)
  );

  typedef struct {
    logic [L*DW-1:0] u;
    logic [L*FW-1:0] v;
    logic            last;
  } exp_t;

  exp_t sb[$];
  exp_t pending;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_in  = 0;
  int   n_out = 0;
  logic in_fired;

  task automatic check(input string tag, input logic [L*DW-1:0] got, input logic [L*DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    return (a >= 0) ? a / d : -((-a + d - 1) / d);
  endfunction

  function automatic exp_t model(input logic [L*DW-1:0] x, input logic [DW-1:0] lf,
                                 input logic s4, input logic last);
    exp_t m;
    longint a, r;
    logic [63:0] rb;
    m.last = last;
    for (int i = 0; i < L; i++) begin
      a = longint'($signed(x[i*DW +: DW])) * 1024;
      if (s4) a = a + longint'($signed(lf));
      a = (a <<< 22) >>> 22;
      r = a + fdiv(a, 2) - fdiv(a, 16);
`ifdef EXP_PRE_PRECISE_EN
      r = r + fdiv(a, 256);
`endif
      rb = r;
      m.u[i*DW +: DW] = rb[41:10];
      m.v[i*FW +: FW] = rb[9:0];
    end
    return m;
  endfunction

  function automatic exp_t rep(input logic [DW-1:0] uu, input logic [FW-1:0] vv, input logic last);
    exp_t m;
    m.last = last;
    for (int i = 0; i < L; i++) begin
      m.u[i*DW +: DW] = uu;
      m.v[i*FW +: FW] = vv;
    end
    return m;
  endfunction

  // Called at a negedge with inputs set; samples just before the next posedge.
  task automatic step();
    exp_t e;
    #4;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got unexpected beat u=%h expected none", u);
      end else begin
        e = sb.pop_front();
        check("u", u, e.u);
        check("v", v, e.v);
        check("last", out_last, e.last);
        n_out++;
        $display("out beat %0d u=%h v=%h last=%0b", n_out, u, v, out_last);
      end
    end
    in_fired = in_valid && in_ready;
    if (in_fired) begin
      sb.push_back(pending);
      n_in++;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [L*DW-1:0] x, input logic [DW-1:0] lf, input logic s4,
                      input logic last, input exp_t e);
    int cnt;
    in_valid = 1'b1; xi = x; lnf = lf; is_stage4 = s4; in_last = last; pending = e;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!in_fired && cnt < 20);
    if (!in_fired) check("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cnt;
    out_ready = 1'b1;
    cnt = 0;
    while (sb.size() > 0 && cnt < 50) begin
      step();
      cnt++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  function automatic logic [DW-1:0] pick_x();
    case ($urandom_range(0, 7))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h0;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int idx, cyc, blocked_at;
    logic [L*DW-1:0] x;
    logic [DW-1:0] lf;
    logic s4, lst;
    logic [FW-1:0] v_a, v_b, v_c, v_d;
`ifdef EXP_PRE_PRECISE_EN
    v_a = 10'd332; v_b = 10'd120; v_c = 10'd166; v_d = 10'd452;
`else
    v_a = 10'd320; v_b = 10'd128; v_c = 10'd160; v_d = 10'd448;
`endif
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_u", u, '0);
    check("rst_v", v, '0);
    check("rst_last", out_last, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);

    // Directed values plus first-beat latency.
    send({L{32'd3}}, '0, 1'b0, 1'b0, rep(32'd4, v_a, 1'b0));
    check("lat_cycle1", out_valid, 1'b0);
    step();
    check("lat_cycle2", out_valid, 1'b1);
    drain();
    send({L{32'hFFFFFFFE}}, '0, 1'b0, 1'b1, rep(32'hFFFFFFFD, v_b, 1'b1));
    send({L{32'd1}}, 32'h200, 1'b1, 1'b0, rep(32'd2, v_c, 1'b0));
    send({L{32'd1}}, 32'h200, 1'b0, 1'b1, rep(32'd1, v_d, 1'b1));
    drain();

    // Backpressure: 4 back-to-back beats, out_ready low for 5 cycles.
    idx = 0;
    blocked_at = -1;
    for (cyc = 0; cyc < 40 && (idx < 4 || sb.size() > 0); cyc++) begin
      out_ready = (cyc >= 5);
      if (idx < 4) begin
        for (int i = 0; i < L; i++) x[i*DW +: DW] = idx * 7 - i * 3 + 5;
        in_valid = 1'b1; xi = x; lnf = 32'hFFFFFE00; is_stage4 = idx[0]; in_last = (idx == 3);
        pending = model(x, 32'hFFFFFE00, idx[0], idx == 3);
        if (!in_ready && blocked_at < 0) blocked_at = idx;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (in_fired) idx++;
    end
    in_valid = 1'b0;
    check("stall_accepted", blocked_at, 2);
    drain();

    // Random traffic.
    idx = 0;
    for (cyc = 0; cyc < 60000 && idx < NRAND; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        for (int i = 0; i < L; i++) x[i*DW +: DW] = pick_x();
        lf = ($urandom_range(0, 3) == 0) ? pick_x() : $urandom_range(0, 4095) - 2048;
        s4 = $urandom_range(0, 1);
        lst = ($urandom_range(0, 7) == 0);
        in_valid = 1'b1; xi = x; lnf = lf; is_stage4 = s4; in_last = lst;
        pending = model(x, lf, s4, lst);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (in_fired) idx++;
    end
    in_valid = 1'b0;
    check("rand_accepted", idx, NRAND);
    drain();
    check("in_out_balance", n_out, n_in);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send({L{32'd9}}, '0, 1'b0, 1'b1, model({L{32'd9}}, '0, 1'b0, 1'b1));
    send({L{32'd10}}, '0, 1'b0, 1'b1, model({L{32'd10}}, '0, 1'b0, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_u", u, '0);
    check("midrst_v", v, '0);
    check("midrst_last", out_last, 1'b0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (4) step();
    check("no_stale", out_valid, 1'b0);
    send({L{32'd3}}, '0, 1'b0, 1'b1, rep(32'd4, v_a, 1'b1));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exp_preprocess_pipe.md
EXP_PREPROCESS_PIPE -- requirements
Module: exp_preprocess_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32; width of Xi, lnF and u per lane.
REQ-002 SHALL have parameter FRAC_W, default 10; fractional bits of lnF and v.
REQ-003 SHALL have parameter LANES, default 4; elements processed per beat.
REQ-004 SHALL have port clk, input, 1; the single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1; asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1; an input beat is present.
REQ-007 SHALL have port in_ready, output, 1; the block accepts the beat this cycle.
REQ-008 SHALL have port xi, input, LANES*DATA_W; signed integer per lane, lane 0 in the LSBs.
REQ-009 SHALL have port lnf, input, DATA_W; signed fixed-point value with FRAC_W fraction bits, shared by all lanes.
REQ-010 SHALL have port is_stage4, input, 1; 1 adds lnf to every lane, 0 adds zero.
REQ-011 SHALL have port in_last, input, 1; end-of-row marker carried alongside the beat.
REQ-012 SHALL have port out_valid, output, 1; a result beat is present.
REQ-013 SHALL have port out_ready, input, 1; downstream accepts the result beat.
REQ-014 SHALL have port u, output, LANES*DATA_W; signed floor (integer part) per lane.
REQ-015 SHALL have port v, output, LANES*FRAC_W; unsigned fraction per lane.
REQ-016 SHALL have port out_last, output, 1; in_last delayed with its beat.

Function
REQ-017 SHALL compute per lane A = (xi<<FRAC_W) + sign-extended (is_stage4 ? lnf : 0), in W = DATA_W+FRAC_W bits, two's complement, wrapping modulo 2^W.
REQ-018 SHALL compute R = A + (A>>>1) - (A>>>4), using arithmetic shifts and W-bit wrapping arithmetic; this approximates multiplication by log2(e).
REQ-019 SHALL drive u = R[W-1:FRAC_W] (floor, also correct for negative R) and v = R[FRAC_W-1:0].
REQ-020 SHALL be a 2-stage pipeline: stage 1 registers A, last and valid; stage 2 registers u, v, last and valid; latency is 2 cycles when not stalled.
REQ-021 SHALL make each stage register load when its valid is 0 or the downstream stage accepts in that cycle; in_ready = !s1_valid || s1_advance.
REQ-022 SHALL sustain a throughput of one beat per cycle while out_ready=1.
REQ-023 SHALL sample is_stage4, lnf and in_last with each accepted beat, so the mode may change on every beat.
REQ-024 SHALL hold out_valid, u, v and out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL lose or duplicate no beat under any out_ready pattern; at most 2 beats are in flight.
REQ-026 SHALL make in_ready combinationally dependent on out_ready, with no combinational path from in_valid to out_valid.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear both valid bits and set u, v and out_last to 0, including during operation.
REQ-028 SHALL discard in-flight beats on reset; in_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL support macro EXP_PRE_PRECISE_EN; when defined, REQ-018 additionally adds (A>>>8), giving a constant of 1.01110001b (1.44140625).
REQ-030 SHALL use a constant of 1.0111b (1.4375) when EXP_PRE_PRECISE_EN is undefined; ports and latency are identical in both builds.

Structure
REQ-031 SHALL place default DATA_W/FRAC_W and the shift-term constants (1, 4, 8) in the shared softmax config header/package.
REQ-032 SHALL implement the per-lane combinational multiply of REQ-018/019 as sub-module exp_pre_lane, instantiated LANES times.

Verification (DATA_W=32, FRAC_W=10; precise-build values in brackets)
REQ-033 SHALL verify: xi=3, is_stage4=0 -> after 2 cycles, u=4, v=320 [332].
REQ-034 SHALL verify: xi=-2, is_stage4=0 -> u=0xFFFFFFFD (-3), v=128 [120].
REQ-035 SHALL verify: xi=1, is_stage4=1, lnf=0x200 (0.5) -> u=2, v=160 [166]; next beat with is_stage4=0, xi=1 -> u=1, v=448 [452].
REQ-036 SHALL verify: 4 back-to-back beats with out_ready=0 for 5 cycles -> in_ready drops after 2 beats accepted; all 4 results emerge in order, out_last aligned.
REQ-037 SHALL verify: random in_valid/out_ready for 10k beats with LANES=4 -> outputs match the reference model per lane; no loss.
REQ-038 SHALL verify: rst_n pulsed low with 2 beats in flight -> out_valid=0 and u=v=0 immediately; no stale beat after release.
